// File: rtl/dot_acc_if.sv
// Operand/result handshake bundle for dot_acc.
// Lane i of in_a/in_b occupies bits [i*WIDTH +: WIDTH].
interface dot_acc_if #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 8
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_first;
    logic                        in_last;
    logic [WIDTH-1:0]            in_bias;
    logic [LANES-1:0][WIDTH-1:0] in_a;
    logic [LANES-1:0][WIDTH-1:0] in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_WIDTH-1:0]        out_data;
    logic                        out_overflow;
    logic                        busy;

    modport master (output in_valid, in_first, in_last, in_bias, in_a, in_b, out_ready,
                    input  in_ready, out_valid, out_data, out_overflow, busy);
    modport slave  (input  in_valid, in_first, in_last, in_bias, in_a, in_b, out_ready,
                    output in_ready, out_valid, out_data, out_overflow, busy);
endinterface

// File: rtl/dot_acc.sv
// Pipelined signed dot-product accumulator.
// S1: operand register, S2: products + adder-tree sum, S3: accumulator + output.
// One global enable stalls every stage while a result waits for the consumer.

// Full-precision signed product of one lane.
module dot_acc_lane #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);
    assign p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
endmodule

module dot_acc #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 8,
    parameter bit SAT       = 1'b0
) (
    input logic      clock,
    input logic      reset,
    dot_acc_if.slave bus
);
    localparam int PW = 2*WIDTH;
    // Tree sum carries enough headroom that no lane combination can overflow it.
    localparam int SW = 2*WIDTH + $clog2(LANES) + 1;
    // Step intermediate wide enough for base + sum without wrapping.
    localparam int TW = ((SW > ACC_WIDTH) ? SW : ACC_WIDTH) + 2;
    localparam logic signed [TW-1:0] ACC_MAX = {{(TW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [TW-1:0] ACC_MIN = {{(TW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                        first;
        logic                        last;
        logic [WIDTH-1:0]            bias;
        logic [LANES-1:0][WIDTH-1:0] a;
        logic [LANES-1:0][WIDTH-1:0] b;
    } beat_t;

    typedef struct packed {
        logic             first;
        logic             last;
        logic [WIDTH-1:0] bias;
        logic [SW-1:0]    sum;
    } prod_t;

    logic                        adv;
    logic [1:0]                  vld_pipe;   // [0] = S1 holds a beat, [1] = S2 holds a beat
    beat_t                       s1_q;
    prod_t                       s2_q;
    logic [LANES-1:0][PW-1:0]    prod;
    logic signed [SW-1:0]        sum;
    logic signed [TW-1:0]        base;
    logic signed [TW-1:0]        t;
    logic                        step_ovf;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic                        ovf_q;
    logic                        ovf_nxt;
    logic                        out_valid_q;
    logic [ACC_WIDTH-1:0]        out_data_q;
    logic                        out_ovf_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && !reset;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.busy         = (|vld_pipe) || out_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dot_acc_lane #(.WIDTH(WIDTH)) u_lane (
            .a (s1_q.a[i]),
            .b (s1_q.b[i]),
            .p (prod[i])
        );
    end

    // Adder tree over the lane products, sign-extended to the full sum width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + SW'($signed(prod[i]));
    end

    // S1/S2 registers and valid shift; in_ready == adv so in_valid here means accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else if (adv) begin
            vld_pipe   <= {vld_pipe[0], bus.in_valid};
            s1_q.first <= bus.in_first;
            s1_q.last  <= bus.in_last;
            s1_q.bias  <= bus.in_bias;
            s1_q.a     <= bus.in_a;
            s1_q.b     <= bus.in_b;
            s2_q.first <= s1_q.first;
            s2_q.last  <= s1_q.last;
            s2_q.bias  <= s1_q.bias;
            s2_q.sum   <= sum;
        end
    end

    // Accumulate step: reload from bias on first, detect range exit, wrap or clamp.
    always_comb begin
        base     = s2_q.first ? TW'($signed(s2_q.bias)) : TW'(acc_q);
        t        = base + TW'($signed(s2_q.sum));
        step_ovf = (t > ACC_MAX) || (t < ACC_MIN);
        ovf_nxt  = (s2_q.first ? 1'b0 : ovf_q) | step_ovf;
        acc_nxt  = t[ACC_WIDTH-1:0];
        if (SAT && (t > ACC_MAX))
            acc_nxt = ACC_MAX[ACC_WIDTH-1:0];
        else if (SAT && (t < ACC_MIN))
            acc_nxt = ACC_MIN[ACC_WIDTH-1:0];
    end

    // S3: accumulator state and output register; a last beat publishes the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vld_pipe[1] && s2_q.last;
            if (vld_pipe[1]) begin
                acc_q <= acc_nxt;
                ovf_q <= ovf_nxt;
                if (s2_q.last) begin
                    out_data_q <= acc_nxt;
                    out_ovf_q  <= ovf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: 8-bit wrap/saturate pair on directed vectors,
// 12-bit/4-lane wrap/saturate pair on a random stream against a wide-integer model.
module tb_dot_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    dot_acc_if #(.WIDTH(8),  .LANES(2), .ACC_WIDTH(8))  i8w ();
    dot_acc_if #(.WIDTH(8),  .LANES(2), .ACC_WIDTH(8))  i8s ();
    dot_acc_if #(.WIDTH(12), .LANES(4), .ACC_WIDTH(20)) i12w ();
    dot_acc_if #(.WIDTH(12), .LANES(4), .ACC_WIDTH(20)) i12s ();

    dot_acc #(.WIDTH(8),  .LANES(2), .ACC_WIDTH(8),  .SAT(1'b0)) u8w  (.clock(clk), .reset(rst), .bus(i8w));
    dot_acc #(.WIDTH(8),  .LANES(2), .ACC_WIDTH(8),  .SAT(1'b1)) u8s  (.clock(clk), .reset(rst), .bus(i8s));
    dot_acc #(.WIDTH(12), .LANES(4), .ACC_WIDTH(20), .SAT(1'b0)) u12w (.clock(clk), .reset(rst), .bus(i12w));
    dot_acc #(.WIDTH(12), .LANES(4), .ACC_WIDTH(20), .SAT(1'b1)) u12s (.clock(clk), .reset(rst), .bus(i12s));

    // 8-bit pair stimulus
    logic            d_valid, d_first, d_last, d_ordy;
    logic [7:0]      d_bias;
    logic [1:0][7:0] d_a, d_b;
    assign i8w.in_valid = d_valid;  assign i8s.in_valid = d_valid;
    assign i8w.in_first = d_first;  assign i8s.in_first = d_first;
    assign i8w.in_last  = d_last;   assign i8s.in_last  = d_last;
    assign i8w.in_bias  = d_bias;   assign i8s.in_bias  = d_bias;
    assign i8w.in_a     = d_a;      assign i8s.in_a     = d_a;
    assign i8w.in_b     = d_b;      assign i8s.in_b     = d_b;
    assign i8w.out_ready = d_ordy;  assign i8s.out_ready = d_ordy;

    // 12-bit pair stimulus
    logic             r_valid, r_first, r_last, r_ordy;
    logic [11:0]      r_bias;
    logic [3:0][11:0] r_a, r_b;
    assign i12w.in_valid = r_valid; assign i12s.in_valid = r_valid;
    assign i12w.in_first = r_first; assign i12s.in_first = r_first;
    assign i12w.in_last  = r_last;  assign i12s.in_last  = r_last;
    assign i12w.in_bias  = r_bias;  assign i12s.in_bias  = r_bias;
    assign i12w.in_a     = r_a;     assign i12s.in_a     = r_a;
    assign i12w.in_b     = r_b;     assign i12s.in_b     = r_b;
    assign i12w.out_ready = r_ordy; assign i12s.out_ready = r_ordy;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int d8w();
        return int'($signed(i8w.out_data));
    endfunction

    // Results handed over by the 8-bit pair
    typedef struct { int dw; bit ow; int ds; bit os; } res_t;
    res_t q8[$];
    always @(negedge clk) begin
        res_t r;
        if (!rst && i8w.out_valid && d_ordy) begin
            r.dw = int'($signed(i8w.out_data));
            r.ow = i8w.out_overflow;
            r.ds = int'($signed(i8s.out_data));
            r.os = i8s.out_overflow;
            q8.push_back(r);
        end
    end

    // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic send8(input bit f, input bit l, input int bias, input int a0, input int a1,
                         input int b0, input int b1);
        bit ok;
        ok = 1'b0;
        d_valid = 1'b1; d_first = f; d_last = l; d_bias = 8'(bias);
        d_a[0] = 8'(a0); d_a[1] = 8'(a1); d_b[0] = 8'(b0); d_b[1] = 8'(b1);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = i8w.in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("send8_accept", 0, 1);
    endtask

    task automatic idle8();
        d_valid = 1'b0; d_first = 1'b0; d_last = 1'b0;
    endtask

    // Wide-integer reference for the 12-bit pair
    localparam longint MAX20 = 524287;
    localparam longint MIN20 = -524288;
    typedef struct { longint d; bit o; } exp_t;
    exp_t   qw[$], qs[$];
    longint accw = 0, accs = 0;
    bit     ovw = 1'b0, ovs = 1'b0;

    task automatic ref_step(input longint acc, input bit ovf, input bit first, input longint bias,
                            input longint sum, input bit sat, output longint acc_o, output bit ovf_o);
        longint t;
        logic signed [19:0] w;
        t = (first ? bias : acc) + sum;
        ovf_o = (first ? 1'b0 : ovf) | (t > MAX20 || t < MIN20);
        if (sat) acc_o = (t > MAX20) ? MAX20 : (t < MIN20) ? MIN20 : t;
        else begin
            w = t[19:0];
            acc_o = longint'(w);
        end
    endtask

    always @(negedge clk) begin
        longint sum;
        exp_t e;
        if (!rst && r_valid && i12w.in_ready) begin
            sum = 0;
            for (int i = 0; i < 4; i++)
                sum += longint'($signed(r_a[i])) * longint'($signed(r_b[i]));
            ref_step(accw, ovw, r_first, longint'($signed(r_bias)), sum, 1'b0, accw, ovw);
            ref_step(accs, ovs, r_first, longint'($signed(r_bias)), sum, 1'b1, accs, ovs);
            if (r_last) begin
                e.d = accw; e.o = ovw; qw.push_back(e);
                e.d = accs; e.o = ovs; qs.push_back(e);
            end
        end
        if (!rst && i12w.out_valid && r_ordy) begin
            if (qw.size() == 0) chk("rnd_wrap_unexpected_result", 1, 0);
            else begin
                e = qw.pop_front();
                chk("rnd_wrap_data", longint'($signed(i12w.out_data)), e.d);
                chk("rnd_wrap_ovf", longint'(i12w.out_overflow), longint'(e.o));
            end
        end
        if (!rst && i12s.out_valid && r_ordy) begin
            if (qs.size() == 0) chk("rnd_sat_unexpected_result", 1, 0);
            else begin
                e = qs.pop_front();
                chk("rnd_sat_data", longint'($signed(i12s.out_data)), e.d);
                chk("rnd_sat_ovf", longint'(i12s.out_overflow), longint'(e.o));
            end
        end
    end

    function automatic logic [11:0] rnd12();
        if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 127) - 64);
        return 12'($urandom_range(0, 4095));
    endfunction

    typedef struct {
        bit first; bit last; int bias; int a0; int a1; int b0; int b1;
        int ew; bit ow; int es; bit os;
    } vec_t;
    vec_t tbl[15];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        res_t r;
        rst = 1'b1; d_ordy = 1'b1; r_ordy = 1'b1;
        idle8(); d_bias = '0; d_a = '0; d_b = '0;
        r_valid = 1'b0; r_first = 1'b0; r_last = 1'b0; r_bias = '0; r_a = '0; r_b = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_in_ready", i8w.in_ready, 0);
        chk("reset_out_valid", i8w.out_valid, 0);
        chk("reset_out_data", i8w.out_data, 0);
        chk("reset_out_ovf", i8w.out_overflow, 0);
        chk("reset_busy", i8w.busy, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Single-beat latency: valid exactly two edges after acceptance
        send8(1, 1, 3, 1, 7, 2, 2); idle8();
        @(negedge clk); chk("lat_e0", i8w.out_valid, 0);
        @(negedge clk); chk("lat_e1", i8w.out_valid, 0);
        @(negedge clk); chk("lat_e2", i8w.out_valid, 1);
        chk("single_data", d8w(), 19);
        chk("single_ovf", i8w.out_overflow, 0);
        @(negedge clk); @(posedge clk); #1; q8.delete();

        // Two-beat frame followed directly by a single-beat frame
        send8(1, 0, 0, 1, 2, 3, 4);
        send8(0, 1, 0, -3, 0, 4, 0);
        send8(1, 1, 0, 2, 2, 1, 1); idle8();
        @(negedge clk); chk("b2b_pre", i8w.out_valid, 0);
        @(negedge clk); chk("b2b_v1", i8w.out_valid, 1); chk("b2b_d1", d8w(), -1);
        @(negedge clk); chk("b2b_v2", i8w.out_valid, 1); chk("b2b_d2", d8w(), 4);
        @(negedge clk); chk("b2b_post", i8w.out_valid, 0);
        chk("b2b_count", q8.size(), 2);
        @(posedge clk); #1; q8.delete();

        // Directed table, streamed back to back
        tbl[0]  = '{1, 1,    3,    1,    7,    2,    2,   19, 0,   19, 0};
        tbl[1]  = '{1, 1,    0,  100,  100,    2,    1,   44, 1,  127, 1};
        tbl[2]  = '{1, 1,    0,    1,    1,    1,    1,    2, 0,    2, 0};
        tbl[3]  = '{1, 1, -128, -128,    0,    1,    0,    0, 1, -128, 1};
        tbl[4]  = '{1, 0,  100,   10,    0,   10,    0,    0, 0,    0, 0};
        tbl[5]  = '{0, 1,    0,  -10,    0,   10,    0,  100, 1,   27, 1};
        tbl[6]  = '{0, 1,    0,    1,    0,    1,    0,  101, 1,   28, 1};
        tbl[7]  = '{1, 1,  127,    0,    0,    0,    0,  127, 0,  127, 0};
        tbl[8]  = '{1, 1, -128,    0,    0,    0,    0, -128, 0, -128, 0};
        tbl[9]  = '{1, 1,  127,    1,    0,    1,    0, -128, 1,  127, 1};
        tbl[10] = '{1, 1,    0, -128, -128, -128, -128,    0, 1,  127, 1};
        tbl[11] = '{1, 1,    0, -128,  127,    1,    1,   -1, 0,   -1, 0};
        tbl[12] = '{1, 0,   -5,    3,    3,    1,    1,    0, 0,    0, 0};
        tbl[13] = '{0, 0,    0,    2,    0,    2,    0,    0, 0,    0, 0};
        tbl[14] = '{0, 1,    0,    0,    1,    0,   -3,    2, 0,    2, 0};
        for (int i = 0; i < 15; i++)
            send8(tbl[i].first, tbl[i].last, tbl[i].bias, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1);
        idle8();
        repeat (6) @(negedge clk);
        chk("tbl_count", q8.size(), 12);
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].last && q8.size() > 0) begin
                r = q8.pop_front();
                chk($sformatf("tbl%0d_wrap_data", i), r.dw, tbl[i].ew);
                chk($sformatf("tbl%0d_wrap_ovf", i), r.ow, tbl[i].ow);
                chk($sformatf("tbl%0d_sat_data", i), r.ds, tbl[i].es);
                chk($sformatf("tbl%0d_sat_ovf", i), r.os, tbl[i].os);
            end
        end
        @(posedge clk); #1; q8.delete();

        // Backpressure: consumer stalls five cycles while the stream keeps coming
        d_ordy = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send8(1, 1, k, k, 1, 1, k);
                idle8();
            end
            begin
                n = 0;
                do begin
                    @(negedge clk); n++;
                end while (!i8w.out_valid && n < 20);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_out_valid", i8w.out_valid, 1);
                    chk("bp_in_ready", i8w.in_ready, 0);
                    chk("bp_data_stable", d8w(), 3);
                end
                @(posedge clk); #1; d_ordy = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("bp_count", q8.size(), 6);
        for (int k = 1; k <= 6 && q8.size() > 0; k++) begin
            r = q8.pop_front();
            chk("bp_wrap_seq", r.dw, 3 * k);
            chk("bp_sat_seq", r.ds, 3 * k);
        end
        @(posedge clk); #1; q8.delete();

        // Reset in the middle of a frame
        send8(1, 0, 5, 9, 9, 9, 9); idle8();
        rst = 1'b1;
        @(negedge clk); chk("rst_in_ready", i8w.in_ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", i8w.busy, 0);
        chk("rst_out_valid", i8w.out_valid, 0);
        @(posedge clk); #1;
        send8(1, 1, 0, 1, 1, 1, 1); idle8();
        repeat (6) @(negedge clk);
        chk("rst_count", q8.size(), 1);
        if (q8.size() > 0) begin
            r = q8.pop_front();
            chk("rst_data", r.dw, 2);
            chk("rst_ovf", r.ow, 0);
        end
        @(posedge clk); #1;

        // Random 4-lane stream with valid and ready gaps, both arithmetic modes
        for (int c = 0; c < 1500; c++) begin
            r_valid = ($urandom_range(0, 9) < 7);
            r_first = ($urandom_range(0, 3) == 0);
            r_last  = ($urandom_range(0, 2) == 0);
            r_ordy  = ($urandom_range(0, 9) < 7);
            r_bias  = rnd12();
            for (int i = 0; i < 4; i++) begin
                r_a[i] = rnd12();
                r_b[i] = rnd12();
            end
            @(posedge clk); #1;
        end
        r_valid = 1'b0; r_ordy = 1'b1;
        n = 0;
        while ((qw.size() != 0 || qs.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("rnd_wrap_drained", qw.size(), 0);
        chk("rnd_sat_drained", qs.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dot_acc.md
Name: dot_acc

Overview:
Parametrised, pipelined, signed dot-product accumulator and the successor to the fixed two-lane dot unit. It generalises element width, lane count and accumulator width, and adds four things the fixed unit lacks:
- multi-beat accumulation over long vectors (first/last framing);
- valid/ready handshakes on input and output;
- selectable wrap or saturate arithmetic;
- a per-result overflow flag.
It sits between operand fetch and the result writeback of the tensor datapath.

Parameters:
WIDTH, 8, signed element and bias width (>=2)
LANES, 2, products summed per beat (>=1)
ACC_WIDTH, 8, signed accumulator/result width (>=WIDTH)
SAT, 0, 0 = two's-complement wrap, 1 = saturate to ACC_WIDTH signed range

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_first  in  1  beat opens a new result; accumulator reloads from in_bias
in_last  in  1  beat closes the result; emit it
in_bias  in  WIDTH  signed bias, sampled only when in_first=1
in_a  in  LANES*WIDTH  signed operands; lane i = bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  signed operands, same packing
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts result
out_data  out  ACC_WIDTH  signed result
out_overflow  out  1  any accumulation step of this result left the ACC_WIDTH range
busy  out  1  any pipeline stage holds a beat, or out_valid=1

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous, active-high, named `reset`.
- Reset state: every stage valid=0; accumulator=0; out_valid=0, out_data=0, out_overflow=0, busy=0. Reset mid-frame discards all in-flight beats and any partial sum. in_ready is 0 during the reset cycle.
- Pipeline stages:
  - S1 registers operands and flags.
  - S2 registers LANES full-precision products (2*WIDTH each) and their adder-tree sum. The sum width is 2*WIDTH+clog2(LANES)+1, so the tree never loses bits.
  - S3 is the accumulator plus the output register.
- Stall rule: global enable `adv = !out_valid || out_ready`. All stages advance only when adv=1, and in_ready = adv.
- Latency: a beat accepted on edge E0 produces out_valid=1 after edge E0+2 when no stall occurs. A stall adds one cycle per stalled cycle.
- Throughput: one beat per cycle with out_ready held high.
- Accumulate step at S3, computed in a wide intermediate:
  - base = sign-extended in_bias if first, else the current acc.
  - t = base + beat sum.
  - If t is outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], set ovf.
  - SAT=0: acc = t[ACC_WIDTH-1:0]. SAT=1: acc = clamp(t).
  - The step is applied every beat, so a multi-beat result saturates at each step, not only at the end.
- Overflow flag: ovf clears on a first beat, then ORs in each step. On a last beat, out_data=acc and out_overflow=ovf are loaded and out_valid is set.
- first && last on the same beat: single-beat result equal to bias + sum.
- Beat without first after reset or after a last: accumulates onto the current acc (0 after reset, the previous result after a last). This is legal, not an error.
- Non-last beats never assert out_valid and never alter the out_data or out_overflow registers.
- Output handshake: out_data and out_overflow stay stable while out_valid && !out_ready. With out_valid && out_ready, a new last beat arriving at S3 in the same cycle replaces the output with out_valid remaining 1 (back-to-back results); otherwise out_valid drops.
- Input don't-cares: in_bias, in_first and in_last are ignored when in_valid=0. Input values change freely while in_ready=0.

Test Plan:
1. Single-beat (WIDTH=8, LANES=2, ACC_WIDTH=8, SAT=0): bias=3, a=(1,7), b=(2,2), first=last=1 -> out_data=19, out_overflow=0, out_valid exactly 2 edges after acceptance.
2. Two-beat frame:
   - beat1 first, bias=0, a=(1,2), b=(3,4); beat2 last, a=(-3,0), b=(4,0) -> out_data=-1 (0xFF), one result only.
   - Follow immediately with a single-beat frame, bias=0, a=(2,2), b=(1,1), out_ready=1 -> next result 4, with out_valid high on consecutive cycles.
3. Overflow, bias=0, a=(100,100), b=(2,1):
   - SAT=0 -> out_data=44, out_overflow=1.
   - SAT=1 rebuild -> out_data=127, out_overflow=1.
   - Next clean frame -> out_overflow=0.
4. Backpressure: hold out_ready=0 for 5 cycles with the input stream continuing -> in_ready=0 while out_valid is held, out_data stable, no beat lost or duplicated. The result sequence after release matches the reference model.
5. Reset mid-frame: accept a first beat, assert reset for one cycle, then send a first=last beat with bias=0, a=(1,1), b=(1,1) -> only result 2 appears; busy=0 and out_valid=0 in the cycle after reset.
6. Random LANES=4, WIDTH=12, ACC_WIDTH=20, both SAT values, random valid and ready gaps: the scoreboard against a golden wide-integer model matches every out_data and out_overflow.
